inst_queue: RTL and testbench

//  Decoded-instruction FIFO sitting directly upstream of the Forward stage.
//  - Buffers decoded ops (is_vec, type, name, rd, pc, imm) from the decoder.
//  - Issues one op per cycle to Forward whenever Forward raises ins_rdy.
//  - Supports a pipeline flush for branch redirects.

---
 rtl/inst_queue_pkg.sv | 26 ++
 rtl/inst_queue_ram.sv | 26 ++
 rtl/inst_queue.sv | 124 ++++++++++++
 tb/tb_inst_queue.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// Shared definitions for the decoded-instruction queue: op classes, field widths
// and the packed entry layout (is_vec, type, name, rd, pc, imm from MSB to LSB).
package inst_queue_pkg;

    localparam int IQ_NAME_W  = 6;
    localparam int IQ_RD_W    = 5;
    localparam int IQ_XLEN    = 32;
    localparam int IQ_ENTRY_W = 78;

    typedef enum logic [1:0] {
        OP_ALU = 2'd0,
        OP_MEM = 2'd1,
        OP_BR  = 2'd2,
        OP_CSR = 2'd3
    } op_class_e;

    typedef struct packed {
        logic                 is_vec;
        op_class_e            op_type;
        logic [IQ_NAME_W-1:0] name;
        logic [IQ_RD_W-1:0]   rd;
        logic [IQ_XLEN-1:0]   pc;
        logic [IQ_XLEN-1:0]   imm;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue_ram.sv
// Entry storage for inst_queue: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module inst_queue_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 78
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/inst_queue.sv
// Decoded-instruction FIFO feeding the Forward stage, with branch-redirect flush.
// Optional same-cycle empty-queue bypass is enabled by defining IQUEUE_BYPASS_EN.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              push,
    input  logic              in_is_vec,
    input  logic [1:0]        in_type,
    input  logic [5:0]        in_name,
    input  logic [4:0]        in_rd,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_imm,
    output logic              full,
    output logic [ADDR_W:0]   count,
    input  logic              ins_rdy,
    output logic              issue_rdy,
    output logic              is_vec,
    output logic [1:0]        op_type,
    output logic [5:0]        name,
    output logic [4:0]        rd,
    output logic [31:0]       pc,
    output logic [31:0]       imm
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] head_q, head_d;
    logic [ADDR_W-1:0] tail_q, tail_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;

    iq_entry_t in_entry, head_entry, out_entry;
    logic      not_empty, pop, accept, bypass;

    assign in_entry = '{is_vec:  in_is_vec,
                        op_type: op_class_e'(in_type),
                        name:    in_name,
                        rd:      in_rd,
                        pc:      in_pc,
                        imm:     in_imm};

    assign not_empty = (count_q != '0);
    assign pop       = rdy & ~flush & ins_rdy & not_empty;

`ifdef IQUEUE_BYPASS_EN
    // An op arriving at an empty queue while Forward is ready skips storage entirely.
    assign bypass    = rdy & ~flush & push & ins_rdy & ~not_empty;
    assign out_entry = bypass ? in_entry : head_entry;
`else
    assign bypass    = 1'b0;
    assign out_entry = head_entry;
`endif

    assign accept    = rdy & push & ~full_q & ~flush & ~bypass;
    assign issue_rdy = pop | bypass;

    inst_queue_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (IQ_ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (accept),
        .waddr_i (tail_q),
        .wdata_i (in_entry),
        .raddr_i (head_q),
        .rdata_o (head_entry)
    );

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        full_d  = full_q;
        if (rdy) begin
            if (flush) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                full_d  = 1'b0;
            end else begin
                if (pop) begin
                    head_d = head_q + ADDR_W'(1);
                end
                if (accept) begin
                    tail_d = tail_q + ADDR_W'(1);
                end
                count_d = count_q + (ADDR_W+1)'(accept) - (ADDR_W+1)'(pop);
                full_d  = (count_d == FULL_CNT);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    assign full    = full_q;
    assign count   = count_q;
    assign is_vec  = out_entry.is_vec;
    assign op_type = out_entry.op_type;
    assign name    = out_entry.name;
    assign rd      = out_entry.rd;
    assign pc      = out_entry.pc;
    assign imm     = out_entry.imm;

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: expected entries are queued on accepted pushes
// and compared in order whenever the queue issues. Honours IQUEUE_BYPASS_EN.
module tb_inst_queue;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        push;
    logic        in_is_vec;
    logic [1:0]  in_type;
    logic [5:0]  in_name;
    logic [4:0]  in_rd;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic        full;
    logic [4:0]  count;
    logic        ins_rdy;
    logic        issue_rdy;
    logic        is_vec;
    logic [1:0]  op_type;
    logic [5:0]  name;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] imm;

    int          n_checks;
    int          n_errors;
    int          n_issued;
    logic [31:0] last_pc;
    logic [77:0] sb[$];

    inst_queue #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .flush     (flush),
        .push      (push),
        .in_is_vec (in_is_vec),
        .in_type   (in_type),
        .in_name   (in_name),
        .in_rd     (in_rd),
        .in_pc     (in_pc),
        .in_imm    (in_imm),
        .full      (full),
        .count     (count),
        .ins_rdy   (ins_rdy),
        .issue_rdy (issue_rdy),
        .is_vec    (is_vec),
        .op_type   (op_type),
        .name      (name),
        .rd        (rd),
        .pc        (pc),
        .imm       (imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check registered state, drive inputs, check the issue side.
    task automatic step(input logic p, input logic [31:0] pcv, input logic ir,
                        input logic fl, input logic en);
        logic [77:0] e;
        logic [77:0] want;
        logic [77:0] got;
        bit          byp;
        bit          exp_issue;
        bit          acc;
        @(negedge clk);
        check("count", count, sb.size());
        check("full", full, sb.size() == 16);
        e = {1'($urandom), 2'($urandom), 6'($urandom), 5'($urandom), pcv, 32'($urandom)};
        {in_is_vec, in_type, in_name, in_rd, in_pc, in_imm} = e;
        push    = p;
        ins_rdy = ir;
        flush   = fl;
        rdy     = en;
        #1;
        byp = 1'b0;
`ifdef IQUEUE_BYPASS_EN
        byp = en && !fl && p && ir && (sb.size() == 0);
`endif
        exp_issue = (en && !fl && ir && (sb.size() != 0)) || byp;
        acc = en && p && !fl && !byp && (sb.size() < 16);
        check("issue_rdy", issue_rdy, exp_issue);
        if (exp_issue) begin
            want = byp ? e : sb.pop_front();
            if (issue_rdy) begin
                got = {is_vec, op_type, name, rd, pc, imm};
                check("entry", got, want);
                last_pc = pc;
                n_issued++;
                $display("issue pc=%08h imm=%08h rd=%0d bypass=%0d", pc, imm, rd, byp);
            end
        end
        if (en && fl) sb.delete();
        else if (acc) sb.push_back(e);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_issued = 0;
        last_pc  = '0;
        rst = 1'b0; rdy = 1'b0; flush = 1'b0; push = 1'b0; ins_rdy = 1'b0;
        {in_is_vec, in_type, in_name, in_rd, in_pc, in_imm} = '0;
        repeat (2) @(negedge clk);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        rst = 1'b1;

        // 1: reset mid-operation, then single-op latency
        for (int i = 0; i < 4; i++) step(1'b1, 32'h50 + i, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        ins_rdy = 1'b1; rdy = 1'b1; push = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async_rst_count", count, 0);
        check("async_rst_full", full, 0);
        check("async_rst_issue", issue_rdy, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 32'h100, 1'b1, 1'b0, 1'b1);
        last_pc = '0;
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        check("t1_pc", last_pc, 32'h100);

        // 2: fill, dropped 17th push, in-order drain
        for (int i = 0; i < 16; i++) step(1'b1, 32'h200 + i, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h999, 1'b0, 1'b0, 1'b1);
        drain(17);

        // 3: push and pop together at full
        for (int i = 0; i < 16; i++) step(1'b1, 32'h300 + i, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h888, 1'b1, 1'b0, 1'b1);
        drain(16);

        // 4: streamed ops across the pointer wrap
        n_issued = 0;
        begin
            int pushed;
            pushed = 0;
            for (int i = 0; i < 60; i++) begin
                if (pushed < 40 && (i % 4) != 3) begin
                    step(1'b1, 32'h4000 + pushed, (i % 2) == 0, 1'b0, 1'b1);
                    pushed++;
                end else begin
                    step(1'b0, 32'h0, (i % 2) == 0, 1'b0, 1'b1);
                end
            end
        end
        drain(20);
        check("t4_issued", n_issued, 40);

        // 5: flush beats push and pop
        for (int i = 0; i < 5; i++) step(1'b1, 32'h500 + i, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h5ff, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b1, 32'h600 + i, 1'b0, 1'b0, 1'b1);
        drain(3);

        // 6: rdy low freezes everything
        for (int i = 0; i < 3; i++) step(1'b1, 32'h700 + i, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h7f0 + i, 1'b1, 1'b0, 1'b0);
        drain(4);
        step(1'b1, 32'h777, 1'b1, 1'b0, 1'b1);
        drain(2);

        @(negedge clk);
        check("final_count", count, sb.size());
        check("final_full", full, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
